backbone_j_collect: RTL and testbench
=====================================

Name: backbone_j_collect

Overview:
- Downstream stage of the backbone J generator: consumes the serial backbone_J double-precision stream (indices 1..J-1, in order) plus the seed backbone value (index 0).
- Deserialises them into one parallel J-entry vector of IEEE-754 doubles.
- Presents the vector with a valid/ready handshake to the per-j consumer logic.
- Pure data movement: no floating-point arithmetic, no FP IP instances.

Parameters:
- J, 14, number of vector entries (slot 0 = backbone, slots 1..J-1 = backbone_J beats)
- TIMEOUT, 64, max idle cycles between beats while filling (used only with the optional feature)
- J_WIDTH (localparam), $clog2(J)+1, width of slot counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- backbone  in  64  seed value, written into slot 0
- backbone_tvalid  in  1  starts a frame; backbone is valid this cycle
- backbone_J  in  64  streamed value for slot 1..J-1
- backbone_J_tvalid  in  1  one beat per cycle when high; no backpressure on this input
- vec_tready  in  1  consumer accepts vector
- err_clr  in  1  clears sticky error bits
- backbone_vec  out  J*64  slot k at bits [k*64 +: 64]
- backbone_vec_tvalid  out  1  vector complete and held
- busy  out  1  high in FILL or HOLD
- err  out  2  sticky: [0] stray/overrun beat, [1] fill timeout

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, slot counter 0, vector register 0. Reset asserted mid-frame discards the partial frame immediately.
- State machine: IDLE, FILL, HOLD.
- IDLE:
  - On backbone_tvalid: slot0 <= backbone, cnt <= 1, go to FILL.
  - backbone_J_tvalid in IDLE: beat dropped, err[0] <= 1.
- FILL:
  - Each backbone_J_tvalid cycle: slot[cnt] <= backbone_J, cnt <= cnt+1.
  - Beat written when cnt == J-1 moves to HOLD.
  - backbone_tvalid in FILL: ignored, slot0 unchanged, err[0] <= 1.
  - backbone_tvalid and backbone_J_tvalid in the same FILL cycle: the beat is written; the seed is flagged as in the previous rule.
- HOLD:
  - backbone_vec_tvalid = 1. backbone_vec is stable until the handshake (tvalid & tready).
  - On handshake: go to IDLE; tvalid falls the next cycle.
  - Handshake and backbone_tvalid in the same cycle: the new seed is accepted, slot0 loaded, cnt <= 1, go to FILL (back-to-back frames, no bubble).
  - backbone_tvalid without handshake: ignored, err[0] <= 1.
  - backbone_J_tvalid in HOLD: dropped, err[0] <= 1; vector not modified.
- Latency: last beat at cycle t gives backbone_vec_tvalid high at t+1. A frame arriving in J consecutive cycles (seed, then J-1 beats) is complete after J+1 cycles.
- Vector updates: slots are written individually. Slots not yet rewritten in a new frame hold the previous frame's values (not cleared); only the HOLD contents are meaningful.
- busy: high in FILL and HOLD.
- err:
  - Bits are sticky; err_clr zeroes them the next cycle.
  - A simultaneous set and err_clr in the same cycle: set wins.
- Bounds: cnt never exceeds J-1; no write outside slots 0..J-1.

Optional Feature:
- Macro: BACKBONE_COLLECT_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every accepted beat and on entry to FILL, and increments on each FILL cycle without a beat.
  - When it reaches TIMEOUT: frame aborted, go to IDLE, err[1] <= 1, backbone_vec_tvalid stays 0.
  - A beat in the same cycle as the count reaching TIMEOUT is accepted and no abort occurs.
- Not defined: no counter logic; FILL waits indefinitely; err[1] tied to 0.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'b00, FILL=2'b01, HOLD=2'b10 (2-bit, matching the generator's state width).
  - Error bit index constants ERR_STRAY=0, ERR_TIMEOUT=1.
  - Double width constant 64.
- Single module; no sub-module warranted. The J x 64 register file and write decode stay inline.

Test Plan:
- J=14: seed 1.0 (0x3FF0000000000000), then 13 consecutive beats k=1..13 carrying value k.0 -> tvalid at cycle after beat 13; slot k == k.0; err == 0.
- tready held low 5 cycles in HOLD while beats 0x4000000000000000 are driven -> vector unchanged, err[0]=1; err_clr -> err==0 next cycle.
- Beats sent with 3-cycle gaps between each -> same vector as gapless case; busy high throughout FILL.
- Handshake and new seed 2.0 in the same HOLD cycle -> FILL entered immediately, slot0=2.0; second frame completes correctly.
- rst_n low after beat 6 -> all outputs 0 asynchronously; a fresh frame after release completes normally.
- With BACKBONE_COLLECT_TIMEOUT_EN, TIMEOUT=8: stop after beat 4 -> abort exactly 8 idle cycles later, err=2'b10, tvalid never rises. Without the macro: module still in FILL, err=0.

Source files
------------

// File: rtl/backbone_j_collect_pkg.sv
// Shared constants and types for the backbone J collector.
//   state_e     : collector FSM state (2-bit, same width as the generator's state)
//   ERR_*       : bit positions inside the sticky err vector
//   DW          : IEEE-754 double width
package backbone_j_collect_pkg;

  localparam int unsigned DW = 64;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam int unsigned ERR_STRAY   = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    HOLD = ST_HOLD
  } state_e;

endpackage

// File: rtl/backbone_j_collect_if.sv
// Stream-in / vector-out bus of the backbone J collector.
//   backbone, backbone_tvalid      : frame seed (slot 0)
//   backbone_J, backbone_J_tvalid  : serial beats for slots 1..J-1, no backpressure
//   backbone_vec, _tvalid, vec_tready : parallel J-entry vector with valid/ready
// master = producer/consumer side, slave = collector.
interface backbone_j_collect_if #(
  parameter int unsigned J = 14
);
  import backbone_j_collect_pkg::*;

  logic [DW-1:0]   backbone;
  logic            backbone_tvalid;
  logic [DW-1:0]   backbone_J;
  logic            backbone_J_tvalid;
  logic            vec_tready;
  logic [J*DW-1:0] backbone_vec;
  logic            backbone_vec_tvalid;

  modport master (
    output backbone, backbone_tvalid, backbone_J, backbone_J_tvalid, vec_tready,
    input  backbone_vec, backbone_vec_tvalid
  );

  modport slave (
    input  backbone, backbone_tvalid, backbone_J, backbone_J_tvalid, vec_tready,
    output backbone_vec, backbone_vec_tvalid
  );

endinterface

// File: rtl/backbone_j_collect.sv
// Deserialises the seed plus J-1 streamed backbone_J doubles into one J-entry
// vector and presents it with valid/ready. Pure data movement.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : backbone_j_collect_if.slave (seed/beat inputs, vector output)
//   err_clr    : clears sticky error bits (a same-cycle set wins)
//   busy       : high while filling or holding a vector
//   err        : sticky [0] stray/overrun beat or seed, [1] fill timeout
// Optional macro BACKBONE_COLLECT_TIMEOUT_EN: aborts a frame after TIMEOUT
// consecutive beat-less FILL cycles; when undefined FILL waits forever.
module backbone_j_collect
  import backbone_j_collect_pkg::*;
#(
  parameter int unsigned J       = 14,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  backbone_j_collect_if.slave  bus,
  input  logic                 err_clr,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam int unsigned J_WIDTH = $clog2(J) + 1;

  state_e               state_q, state_d;
  logic [J_WIDTH-1:0]   cnt_q, cnt_d;
  logic [J*DW-1:0]      vec_q;
  logic                 tvalid_q;
  logic                 wr_en;
  logic [J_WIDTH-1:0]   wr_idx;
  logic [DW-1:0]        wr_data;
  logic [1:0]           err_set;
  logic [1:0]           err_d;

`ifdef BACKBONE_COLLECT_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]    idle_q, idle_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  assign bus.backbone_vec        = vec_q;
  assign bus.backbone_vec_tvalid = tvalid_q;

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      busy     <= 1'b0;
      err      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tvalid_q <= (state_d == HOLD);
      busy     <= (state_d != IDLE);
      err      <= err_d;
    end
  end

`ifdef BACKBONE_COLLECT_TIMEOUT_EN
  // Beat-less FILL cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  // Slot register file; only the addressed slot changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
    end else begin
      for (int k = 0; k < int'(J); k++) begin
        if (wr_en && (wr_idx == J_WIDTH'(k))) vec_q[k*DW +: DW] <= wr_data;
      end
    end
  end

  // Next-state, slot write decode and error set
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = bus.backbone;
    err_set = '0;
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
    idle_d  = idle_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.backbone_tvalid) begin
          wr_en   = 1'b1;
          cnt_d   = J_WIDTH'(1);
          state_d = FILL;
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
        if (bus.backbone_J_tvalid) err_set[ERR_STRAY] = 1'b1;
      end

      FILL: begin
        if (bus.backbone_tvalid) err_set[ERR_STRAY] = 1'b1;
        if (bus.backbone_J_tvalid) begin
          wr_en   = 1'b1;
          wr_idx  = cnt_q;
          wr_data = bus.backbone_J;
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
          idle_d  = '0;
`endif
          // Counter parks at 0 once the last slot is written
          if (cnt_q == J_WIDTH'(J - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d   = cnt_q + J_WIDTH'(1);
          end
        end else begin
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
          // This beat-less cycle brings the count to TIMEOUT: abort
          if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
            idle_d                = '0;
            cnt_d                 = '0;
            state_d               = IDLE;
            err_set[ERR_TIMEOUT]  = 1'b1;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
`endif
        end
      end

      HOLD: begin
        if (bus.backbone_J_tvalid) err_set[ERR_STRAY] = 1'b1;
        if (bus.vec_tready) begin
          // Handshake with a fresh seed restarts filling without a bubble
          if (bus.backbone_tvalid) begin
            wr_en   = 1'b1;
            cnt_d   = J_WIDTH'(1);
            state_d = FILL;
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
            idle_d  = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (bus.backbone_tvalid) begin
          err_set[ERR_STRAY] = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Clear first so a same-cycle set survives
    err_d = (err_clr ? 2'b00 : err) | err_set;
  end

endmodule

// File: tb/tb_backbone_j_collect.sv
// Directed bench for backbone_j_collect with an expected-vector scoreboard.
module tb_backbone_j_collect;

  localparam int unsigned J       = 14;
  localparam int unsigned TIMEOUT = 8;

  typedef logic [J*64-1:0] vec_t;

  logic       clk;
  logic       rst_n;
  logic       err_clr;
  logic       busy;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];

  backbone_j_collect_if #(.J(J)) bus ();

  backbone_j_collect #(.J(J), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .err_clr (err_clr),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] dbl(input real r);
    return $realtobits(r);
  endfunction

  function automatic vec_t build(input real seed, input real off);
    vec_t v;
    v[63:0] = dbl(seed);
    for (int k = 1; k < int'(J); k++) v[k*64 +: 64] = dbl(real'(k) + off);
    return v;
  endfunction

  task automatic drive_seed(input real seed);
    bus.backbone        = dbl(seed);
    bus.backbone_tvalid = 1'b1;
    tick();
    bus.backbone_tvalid = 1'b0;
  endtask

  // Beats first..last carry k+off; gap idle cycles follow every beat but the last
  task automatic drive_beats(input int first, input int last, input real off, input int gap);
    for (int k = first; k <= last; k++) begin
      bus.backbone_J       = dbl(real'(k) + off);
      bus.backbone_J_tvalid = 1'b1;
      tick();
      bus.backbone_J_tvalid = 1'b0;
      if (k != last) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("busy_in_gap", 64'(busy), 64'(1));
        end
      end
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.backbone_vec_tvalid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("tvalid_wait", 64'(bus.backbone_vec_tvalid), 64'(1));
  endtask

  // Pop the oldest expected vector and compare it slot by slot
  task automatic check_vec(input string tag);
    vec_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < int'(J); k++)
        chk($sformatf("%s_slot%0d", tag, k), bus.backbone_vec[k*64 +: 64], e[k*64 +: 64]);
    end
  endtask

  vec_t cur;

  initial begin
    rst_n                 = 1'b0;
    err_clr               = 1'b0;
    bus.backbone          = '0;
    bus.backbone_tvalid   = 1'b0;
    bus.backbone_J        = '0;
    bus.backbone_J_tvalid = 1'b0;
    bus.vec_tready        = 1'b0;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    for (int k = 0; k < int'(J); k++) chk("rst_vec", bus.backbone_vec[k*64 +: 64], 64'(0));

    // Gapless frame: seed 1.0 then k.0 for k=1..13
    exp_q.push_back(build(1.0, 0.0));
    drive_seed(1.0);
    chk("fill_busy", 64'(busy), 64'(1));
    drive_beats(1, int'(J) - 2, 0.0, 0);
    chk("early_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    drive_beats(int'(J) - 1, int'(J) - 1, 0.0, 0);
    chk("latency_tvalid", 64'(bus.backbone_vec_tvalid), 64'(1));
    chk("frame_a_err", 64'(err), 64'(0));
    cur = bus.backbone_vec;
    check_vec("frame_a");

    // Stray beats while held without tready
    bus.backbone_J        = 64'h4000000000000000;
    bus.backbone_J_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_tvalid", 64'(bus.backbone_vec_tvalid), 64'(1));
    end
    bus.backbone_J_tvalid = 1'b0;
    exp_q.push_back(cur);
    check_vec("hold_stable");
    chk("stray_err", 64'(err), 64'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 64'(err), 64'(0));
    bus.vec_tready = 1'b1;
    tick();
    bus.vec_tready = 1'b0;
    chk("hs_tvalid_fall", 64'(bus.backbone_vec_tvalid), 64'(0));
    chk("hs_idle_busy", 64'(busy), 64'(0));

    // Gapped frame gives the same vector
    exp_q.push_back(build(1.0, 0.0));
    drive_seed(1.0);
    drive_beats(1, int'(J) - 1, 0.0, 3);
    wait_valid(4);
    check_vec("frame_gap");

    // Handshake plus new seed 2.0 in the same cycle
    exp_q.push_back(build(2.0, 0.5));
    bus.vec_tready = 1'b1;
    drive_seed(2.0);
    bus.vec_tready = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    chk("b2b_slot0", bus.backbone_vec[63:0], dbl(2.0));
    drive_beats(1, int'(J) - 1, 0.5, 0);
    chk("b2b_done", 64'(bus.backbone_vec_tvalid), 64'(1));
    chk("b2b_err", 64'(err), 64'(0));
    check_vec("frame_b2b");
    bus.vec_tready = 1'b1;
    tick();
    bus.vec_tready = 1'b0;

    // Asynchronous reset after beat 6 drops the partial frame
    drive_seed(3.0);
    drive_beats(1, 6, 0.25, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    for (int k = 0; k < int'(J); k++) chk("arst_vec", bus.backbone_vec[k*64 +: 64], 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(build(4.0, 0.75));
    drive_seed(4.0);
    drive_beats(1, int'(J) - 1, 0.75, 0);
    wait_valid(2);
    check_vec("frame_post_rst");
    bus.vec_tready = 1'b1;
    tick();
    bus.vec_tready = 1'b0;

    // Stall after beat 4
    drive_seed(5.0);
    drive_beats(1, 4, 0.0, 0);
`ifdef BACKBONE_COLLECT_TIMEOUT_EN
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      tick();
      chk("to_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    end
    chk("to_busy_before", 64'(busy), 64'(1));
    tick();
    chk("to_busy_after", 64'(busy), 64'(0));
    chk("to_err", 64'(err), 64'(2));
    chk("to_tvalid_end", 64'(bus.backbone_vec_tvalid), 64'(0));
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_tvalid", 64'(bus.backbone_vec_tvalid), 64'(0));
    end
    chk("stall_busy", 64'(busy), 64'(1));
    chk("stall_err", 64'(err), 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
